// File: rtl/control_botones_pkg.sv
// Shared constants and helpers for the push-button conditioning block.
// Holds the debounce lengths and the debounce counter width function.
package control_botones_pkg;

   localparam int unsigned DEBOUNCE_COUNT_DEFAULT = 1_000_000;
   localparam int unsigned DEBOUNCE_COUNT_SIM     = 8;

   // Width of a counter that must reach DEBOUNCE_COUNT-1; never narrower than one bit.
   function automatic int unsigned debounce_cnt_width(input int unsigned count);
      if (count <= 2) begin
         return 1;
      end
      return $clog2(count);
   endfunction

endpackage

// File: rtl/debounce_boton.sv
// Two-flop synchroniser, stability counter and debounced level for one raw button.
// o_press is combinational and marks the edge on which a 0->1 level is accepted.
module debounce_boton
   import control_botones_pkg::*;
#(
   parameter int unsigned DEBOUNCE_COUNT = DEBOUNCE_COUNT_DEFAULT
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_db,
   output logic o_press
);

   localparam int unsigned CntW = debounce_cnt_width(DEBOUNCE_COUNT);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_COUNT - 1);

   logic            r_sync1;
   logic            r_sync2;
   logic            r_db;
   logic [CntW-1:0] r_cnt;
   logic            w_accept;
   logic            w_db_next;
   logic [CntW-1:0] w_cnt_next;

   assign w_accept = (r_sync2 != r_db) && (r_cnt == CntMax);

   always_comb begin
      w_db_next  = r_db;
      w_cnt_next = r_cnt;
      // Any return to the current level restarts the full count.
      if (r_sync2 == r_db) begin
         w_cnt_next = '0;
      end else if (w_accept) begin
         w_db_next  = r_sync2;
         w_cnt_next = '0;
      end else begin
         w_cnt_next = r_cnt + CntW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_db    <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_db    <= w_db_next;
         r_cnt   <= w_cnt_next;
      end
   end

   assign o_db    = r_db;
   assign o_press = w_accept & r_sync2;

endmodule

// File: rtl/control_botones.sv
// Start/stop and clear button conditioning for the 00-99 counter stage.
// Start/stop presses toggle the enable level; clear presses give a one-cycle pulse.
module control_botones
   import control_botones_pkg::*;
#(
   parameter int unsigned DEBOUNCE_COUNT = DEBOUNCE_COUNT_DEFAULT,
   parameter logic        INIT_ENABLE    = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_start_stop,
   input  logic btn_clear,
   output logic enable,
   output logic clear,
   output logic btn_start_stop_db,
   output logic btn_clear_db
);

   logic w_press_ss;
   logic w_press_clr;
   logic r_enable;
   logic r_clear;
   logic w_enable_next;

   debounce_boton #(
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
   ) u_db_start_stop (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_btn   (btn_start_stop),
      .o_db    (btn_start_stop_db),
      .o_press (w_press_ss)
   );

   debounce_boton #(
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
   ) u_db_clear (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_btn   (btn_clear),
      .o_db    (btn_clear_db),
      .o_press (w_press_clr)
   );

   always_comb begin
      w_enable_next = r_enable;
      if (w_press_ss) begin
         w_enable_next = ~r_enable;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_enable <= INIT_ENABLE;
         r_clear  <= 1'b0;
      end else begin
         r_enable <= w_enable_next;
         r_clear  <= w_press_clr;
      end
   end

   assign enable = r_enable;
   assign clear  = r_clear;

endmodule
